// File: rtl/sys_out_packer.sv
`default_nettype none
// ============================================================================
// Module      : sys_out_packer
// Description : Result write-back packer. Buffers complete COL-lane result
//               rows in a small row FIFO and serializes the head row into
//               32-bit words on a valid/ready stream. Rows arriving while
//               the FIFO is full are dropped and flagged with sticky ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_out_packer #(
  parameter int WIDTH = 16,  // lane width, must divide 32
  parameter int COL   = 32,  // lanes per row, multiple of 32/WIDTH
  parameter int DEPTH = 2    // row FIFO depth, power of two >= 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data [COL],
  output logic             in_ready,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  input  logic             ovf_clr,
  output logic             ovf,
  output logic [15:0]      rows_out
);

  // Derived geometry
  localparam int c_lpw   = 32 / WIDTH;            // lanes per output word
  localparam int c_wpr   = COL / c_lpw;           // words per row
  localparam int c_row_w = COL * WIDTH;           // bits per stored row
  localparam int c_pw    = $clog2(DEPTH);         // FIFO pointer width
  localparam int c_cw    = $clog2(DEPTH + 1);     // occupancy width (0..DEPTH)
  localparam int c_ww    = (c_wpr > 1) ? $clog2(c_wpr) : 1;  // word index width

  localparam logic [c_cw-1:0] c_depth     = c_cw'(DEPTH);
  localparam logic [c_ww-1:0] c_widx_last = c_ww'(c_wpr - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Registered state
  state_t              r_state;
  logic [c_pw-1:0]     r_wr_ptr;
  logic [c_pw-1:0]     r_rd_ptr;
  logic [c_cw-1:0]     r_cnt;
  logic [c_ww-1:0]     r_widx;
  logic                r_ovf;
  logic [15:0]         r_rows_out;
  logic [c_row_w-1:0]  r_mem [DEPTH];

  // Combinational helpers
  logic [c_row_w-1:0]  w_row;
  logic [c_row_w-1:0]  w_head;
  logic [31:0]         w_words [c_wpr];
  logic                w_wr;
  logic                w_hs;
  logic                w_pop;
  logic                w_drop;
  logic [c_cw-1:0]     w_cnt_nxt;

  // Flatten the incoming lane array; lane 0 occupies the least significant bits
  // so that consecutive lanes fill each 32-bit word from the bottom up.
  generate
    for (genvar g = 0; g < COL; g++) begin : g_pack
      assign w_row[g*WIDTH +: WIDTH] = in_data[g];
    end
  endgenerate

  // Slice the head row into output words; word k holds lanes k*LPW..k*LPW+LPW-1.
  assign w_head = r_mem[r_rd_ptr];
  generate
    for (genvar k = 0; k < c_wpr; k++) begin : g_words
      assign w_words[k] = w_head[k*32 +: 32];
    end
  endgenerate

  // in_ready depends only on registered occupancy, never on in_vld/m_ready.
  assign in_ready = (r_cnt != c_depth);
  assign m_valid  = (r_state == ST_STREAM);
  assign m_last   = m_valid && (r_widx == c_widx_last);
  assign m_data   = w_words[r_widx];
  assign ovf      = r_ovf;
  assign rows_out = r_rows_out;

  assign w_wr   = in_vld && in_ready;
  assign w_drop = in_vld && !in_ready;
  assign w_hs   = m_valid && m_ready;
  assign w_pop  = w_hs && (r_widx == c_widx_last);

  // Next occupancy: a write and a final-word pop in the same cycle cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr && !w_pop) begin
      w_cnt_nxt = r_cnt + c_cw'(1);
    end else if (!w_wr && w_pop) begin
      w_cnt_nxt = r_cnt - c_cw'(1);
    end
  end

  // Row storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_row;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_pw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_pw'(1);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // Streaming FSM: walks the word index across the head row and decides
  // whether to continue straight into the next row without a bubble.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_widx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_widx <= '0;
          if (r_cnt != '0) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_hs) begin
            if (r_widx == c_widx_last) begin
              r_widx <= '0;
              if (w_cnt_nxt == '0) begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_widx <= r_widx + c_ww'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_widx  <= '0;
        end
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Count of fully transmitted rows, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rows_out <= '0;
    end else if (w_pop) begin
      r_rows_out <= r_rows_out + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_out_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_out_packer
// Description : Directed self-checking bench for sys_out_packer at default
//               parameters (WIDTH=16, COL=32, DEPTH=2, 16 words per row).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_out_packer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_vld;
  logic [15:0] in_data [32];
  logic        in_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        ovf_clr;
  logic        ovf;
  logic [15:0] rows_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sys_out_packer #(.WIDTH(16), .COL(32), .DEPTH(2)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_ready (in_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .rows_out (rows_out)
  );

  always #5 clk = ~clk;

  // Expected word w of a row whose lane i holds base+i.
  function automatic logic [31:0] exp_word(input logic [15:0] base, input int w);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = base + 16'(2 * w);
    hi = base + 16'(2 * w + 1);
    return {hi, lo};
  endfunction

  task automatic set_row(input logic [15:0] base);
    for (int i = 0; i < 32; i++) in_data[i] = base + 16'(i);
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic push_row(input logic [15:0] base);
    set_row(base);
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0; in_vld = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_vld = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else pass_cnt++;
    total_cnt++; if (rows_out !== 16'd0) $display("FAIL reset_rows_out got %0d want 0", rows_out); else pass_cnt++;
    nrst = 1'b1;
  endtask

  task automatic test_single_row();
    do_reset();
    m_ready = 1'b1;
    push_row(16'h0100);
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_latency_early got %b want 0", m_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL single_latency got %b want 1", m_valid); else pass_cnt++;
    for (int w = 0; w < 16; w++) begin
      total_cnt++;
      if (m_valid !== 1'b1 || m_data !== exp_word(16'h0100, w) || m_last !== (w == 15))
        $display("FAIL single_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 w, m_valid, m_data, m_last, exp_word(16'h0100, w), (w == 15));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_valid_fall got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (rows_out !== 16'd1) $display("FAIL single_rows_out got %0d want 1", rows_out); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    int  hs;
    bit  started;
    hs = 0; started = 1'b0;
    do_reset();
    push_row(16'h0200);
    for (int c = 0; c < 200 && hs < 16; c++) begin
      if (m_valid) started = 1'b1;
      if (started) begin
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp_word(16'h0200, hs) || m_last !== (hs == 15))
          $display("FAIL bp_word%0d cyc%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   hs, c, m_valid, m_data, m_last, exp_word(16'h0200, hs), (hs == 15));
        else pass_cnt++;
      end
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      if (m_valid && m_ready) hs++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    total_cnt++; if (hs != 16) $display("FAIL bp_handshakes got %0d want 16", hs); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL bp_valid_fall got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (rows_out !== 16'd1) $display("FAIL bp_rows_out got %0d want 1", rows_out); else pass_cnt++;
  endtask

  task automatic test_full_overflow();
    int k;
    k = 0;
    do_reset();
    set_row(16'h0300); in_vld = 1'b1;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_one got %b want 1", in_ready); else pass_cnt++;
    set_row(16'h0400);
    @(negedge clk);
    in_vld = 1'b0;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_ready_two got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL full_ovf_pre got %b want 0", ovf); else pass_cnt++;
    push_row(16'h0500);
    total_cnt++; if (ovf !== 1'b1) $display("FAIL full_ovf_set got %b want 1", ovf); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_ready_drop got %b want 0", in_ready); else pass_cnt++;
    ovf_clr = 1'b1;
    push_row(16'h0600);
    ovf_clr = 1'b0;
    total_cnt++; if (ovf !== 1'b1) $display("FAIL full_ovf_priority got %b want 1", ovf); else pass_cnt++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL full_ovf_clear got %b want 0", ovf); else pass_cnt++;
    m_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (m_valid) begin
        total_cnt++;
        if (k >= 32)
          $display("FAIL full_extra_word got d=%h want no word", m_data);
        else if (m_data !== exp_word((k < 16) ? 16'h0300 : 16'h0400, k % 16) || m_last !== (k % 16 == 15))
          $display("FAIL full_word%0d got d=%h l=%b want d=%h l=%b", k, m_data, m_last,
                   exp_word((k < 16) ? 16'h0300 : 16'h0400, k % 16), (k % 16 == 15));
        else pass_cnt++;
        k++;
      end
      @(negedge clk);
    end
    total_cnt++; if (k != 32) $display("FAIL full_word_count got %0d want 32", k); else pass_cnt++;
    total_cnt++; if (rows_out !== 16'd2) $display("FAIL full_rows_out got %0d want 2", rows_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int g;
    int r;
    int exp_r;
    do_reset();
    m_ready = 1'b1;
    for (int n = 0; n <= 66; n++) begin
      exp_r = (n >= 18) ? ((n - 18) / 16 + 1) : 0;
      if (exp_r > 4) exp_r = 4;
      g = n - 2;
      if (n >= 2 && g < 64) begin
        r = g / 16;
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp_word(16'h1000 + 16'(r * 256), g % 16) ||
            m_last !== (g % 16 == 15) || in_ready !== 1'b1)
          $display("FAIL b2b_word%0d got v=%b d=%h l=%b rdy=%b want v=1 d=%h l=%b rdy=1",
                   g, m_valid, m_data, m_last, in_ready,
                   exp_word(16'h1000 + 16'(r * 256), g % 16), (g % 16 == 15));
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL b2b_idle_n%0d got v=%b want 0", n, m_valid); else pass_cnt++;
      end
      total_cnt++;
      if (rows_out !== 16'(exp_r)) $display("FAIL b2b_rows_n%0d got %0d want %0d", n, rows_out, exp_r);
      else pass_cnt++;
      if (n == 0 || n == 17 || n == 33 || n == 49) begin
        set_row(16'h1000 + 16'(((n == 0) ? 0 : (n - 1) / 16) * 256));
        in_vld = 1'b1;
      end else begin
        in_vld = 1'b0;
      end
      @(negedge clk);
    end
    in_vld = 1'b0;
  endtask

  task automatic test_mid_row_reset();
    do_reset();
    m_ready = 1'b1;
    push_row(16'h0700);
    repeat (17) @(negedge clk);
    total_cnt++; if (rows_out !== 16'd1) $display("FAIL mid_pre_rows got %0d want 1", rows_out); else pass_cnt++;
    m_ready = 1'b0;
    push_row(16'h0800);
    push_row(16'h0900);
    push_row(16'h0A00);
    total_cnt++; if (ovf !== 1'b1) $display("FAIL mid_pre_ovf got %b want 1", ovf); else pass_cnt++;
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (m_valid !== 1'b1 || m_data !== exp_word(16'h0800, 6))
      $display("FAIL mid_word6 got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp_word(16'h0800, 6));
    else pass_cnt++;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b0) $display("FAIL mid_rst_last got %b want 0", m_last); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (rows_out !== 16'd0) $display("FAIL mid_rst_rows got %0d want 0", rows_out); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL mid_rst_ovf got %b want 0", ovf); else pass_cnt++;
    push_row(16'h0B00);
    @(negedge clk);
    for (int w = 0; w < 16; w++) begin
      total_cnt++;
      if (m_valid !== 1'b1 || m_data !== exp_word(16'h0B00, w) || m_last !== (w == 15))
        $display("FAIL mid_fresh_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 w, m_valid, m_data, m_last, exp_word(16'h0B00, w), (w == 15));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (rows_out !== 16'd1) $display("FAIL mid_fresh_rows got %0d want 1", rows_out); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_fresh_fall got %b want 0", m_valid); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.r_rows_out = 16'hFFFF;
    #1;
    release dut.r_rows_out;
    total_cnt++; if (rows_out !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", rows_out); else pass_cnt++;
    m_ready = 1'b1;
    push_row(16'h0C00);
    repeat (16) @(negedge clk);
    total_cnt++;
    if (m_last !== 1'b1 || rows_out !== 16'hFFFF)
      $display("FAIL wrap_before got l=%b rows=%h want l=1 rows=ffff", m_last, rows_out);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (rows_out !== 16'h0000) $display("FAIL wrap_rows got %h want 0000", rows_out); else pass_cnt++;
  endtask

  initial begin
    nrst = 1'b0; in_vld = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    set_row(16'h0000);
    test_reset();
    test_single_row();
    test_back_pressure();
    test_full_overflow();
    test_back_to_back();
    test_mid_row_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
